nn_training_sequencer: RTL and testbench

Drives the XOR `NeuralNetwork` through a full training run. It holds the internal 4-entry training dataset ROM, applies each sample for exactly one 8-cycle forward/back-propagation/write-back period, and repeats this for a programmable number of epochs. It then switches the network to test mode and scores the network's `predicted` output against its `expected` output over the same 4 samples. It sits directly upstream of `NeuralNetwork`: it drives `reset`, `reset_value`, `TestFlag`, `x_input` and `y_input`, and it consumes `predicted` and `expected`.

---
 rtl/nn_training_sequencer.sv | 165 ++++++++++++++++
 tb/tb_nn_training_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/nn_training_sequencer.sv
// Sequencer for the XOR NeuralNetwork: initialises it, trains it for EPOCHS passes
// over a 4-sample ROM, then scores predicted against expected in test mode.
module nn_training_sequencer #(
   parameter int EPOCHS        = 1000,
   parameter int EPOCH_W       = 16,
   parameter int SAMPLE_CYCLES = 8,
   parameter int TEST_CYCLES   = 2,
   parameter int INIT_CYCLES   = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [1:0]         predicted,
   input  logic [1:0]         expected,
   output logic               nn_reset,
   output logic               nn_reset_value,
   output logic               test_flag,
   output logic               x_input,
   output logic               y_input,
   output logic               busy,
   output logic               done,
   output logic [EPOCH_W-1:0] epoch_count,
   output logic [2:0]         correct_count,
   output logic               pass,
   output logic               protocol_err
);

   localparam int MAX_IT   = (SAMPLE_CYCLES > INIT_CYCLES) ? SAMPLE_CYCLES : INIT_CYCLES;
   localparam int MAX_HOLD = (TEST_CYCLES > MAX_IT) ? TEST_CYCLES : MAX_IT;
   localparam int HOLD_W   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

   localparam logic [HOLD_W-1:0]  INIT_LAST   = HOLD_W'(INIT_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  SAMPLE_LAST = HOLD_W'(SAMPLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  TEST_LAST   = HOLD_W'(TEST_CYCLES - 1);
   localparam logic [EPOCH_W-1:0] EPOCH_LAST  = EPOCH_W'(EPOCHS - 1);

   typedef enum logic [2:0] {IDLE, INIT, TRAIN, TEST, DONE} state_t;

   state_t              state, state_d;
   logic                start_pending, start_pending_d;
   logic [HOLD_W-1:0]   hold_cnt, hold_cnt_d;
   logic [1:0]          sample_idx, sample_idx_d;
   logic [EPOCH_W-1:0]  epoch_d;
   logic [2:0]          correct_d;
   logic                err_d;
   logic                code_invalid;
   logic                nn_reset_d, test_flag_d, x_d, y_d, busy_d, done_d, pass_d;

   assign code_invalid = (predicted == 2'b00) || (expected == 2'b00);

   // State, counters and every output are registered; outputs are decoded from the
   // next-state values so they line up with the state they describe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         start_pending  <= 1'b0;
         hold_cnt       <= '0;
         sample_idx     <= '0;
         epoch_count    <= '0;
         correct_count  <= '0;
         protocol_err   <= 1'b0;
         nn_reset       <= 1'b0;
         nn_reset_value <= 1'b0;
         test_flag      <= 1'b0;
         x_input        <= 1'b0;
         y_input        <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
      end else begin
         state          <= state_d;
         start_pending  <= start_pending_d;
         hold_cnt       <= hold_cnt_d;
         sample_idx     <= sample_idx_d;
         epoch_count    <= epoch_d;
         correct_count  <= correct_d;
         protocol_err   <= err_d;
         nn_reset       <= nn_reset_d;
         nn_reset_value <= nn_reset_d;
         test_flag      <= test_flag_d;
         x_input        <= x_d;
         y_input        <= y_d;
         busy           <= busy_d;
         done           <= done_d;
         pass           <= pass_d;
      end
   end

   // A sampled start takes one extra cycle to launch INIT, so busy rises one edge
   // after the edge that saw start.
   always_comb begin
      state_d         = state;
      start_pending_d = 1'b0;
      hold_cnt_d      = hold_cnt;
      sample_idx_d    = sample_idx;
      epoch_d         = epoch_count;
      correct_d       = correct_count;
      err_d           = protocol_err;
      case (state)
         IDLE, DONE: begin
            start_pending_d = start;
            if (start_pending) begin
               state_d         = INIT;
               start_pending_d = 1'b0;
               hold_cnt_d      = '0;
               sample_idx_d    = '0;
               epoch_d         = '0;
               correct_d       = '0;
               err_d           = 1'b0;
            end
         end
         INIT: begin
            if (hold_cnt == INIT_LAST) begin
               state_d      = TRAIN;
               hold_cnt_d   = '0;
               sample_idx_d = '0;
            end else begin
               hold_cnt_d = hold_cnt + HOLD_W'(1);
            end
         end
         TRAIN: begin
            if (hold_cnt == SAMPLE_LAST) begin
               hold_cnt_d   = '0;
               sample_idx_d = sample_idx + 2'd1;
               if (sample_idx == 2'd3) begin
                  epoch_d = epoch_count + EPOCH_W'(1);
                  if (epoch_count == EPOCH_LAST) begin
                     state_d = TEST;
                  end
               end
            end else begin
               hold_cnt_d = hold_cnt + HOLD_W'(1);
            end
         end
         TEST: begin
            if (hold_cnt == TEST_LAST) begin
               hold_cnt_d   = '0;
               sample_idx_d = sample_idx + 2'd1;
               if (code_invalid) begin
                  err_d = 1'b1;
               end else if ((predicted == expected) && (correct_count != 3'd4)) begin
                  correct_d = correct_count + 3'd1;
               end
               if (sample_idx == 2'd3) begin
                  state_d = DONE;
               end
            end else begin
               hold_cnt_d = hold_cnt + HOLD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      nn_reset_d  = (state_d == INIT);
      test_flag_d = (state_d == TEST);
      x_d         = ((state_d == TRAIN) || (state_d == TEST)) && sample_idx_d[1];
      y_d         = ((state_d == TRAIN) || (state_d == TEST)) && sample_idx_d[0];
      busy_d      = (state_d == INIT) || (state_d == TRAIN) || (state_d == TEST);
      done_d      = (state_d == DONE);
      pass_d      = (state_d == DONE) && (correct_d == 3'd4);
   end

endmodule

// File: tb/tb_nn_training_sequencer.sv
// Directed bench for nn_training_sequencer with EPOCHS = 2; timing is tracked as
// cycles after the edge that samples start.
module tb_nn_training_sequencer;

   localparam int EPOCHS = 2;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [1:0]  predicted;
   logic [1:0]  expected;
   logic        nn_reset;
   logic        nn_reset_value;
   logic        test_flag;
   logic        x_input;
   logic        y_input;
   logic        busy;
   logic        done;
   logic [15:0] epoch_count;
   logic [2:0]  correct_count;
   logic        pass;
   logic        protocol_err;

   int compared = 0;
   int mismatched = 0;

   nn_training_sequencer #(.EPOCHS(EPOCHS)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .predicted      (predicted),
      .expected       (expected),
      .nn_reset       (nn_reset),
      .nn_reset_value (nn_reset_value),
      .test_flag      (test_flag),
      .x_input        (x_input),
      .y_input        (y_input),
      .busy           (busy),
      .done           (done),
      .epoch_count    (epoch_count),
      .correct_count  (correct_count),
      .pass           (pass),
      .protocol_err   (protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] required);
      compared++;
      assert (observed === required) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, required);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_nn_reset"}, 32'(nn_reset), 32'd0);
      check_output({tag, "_nn_reset_value"}, 32'(nn_reset_value), 32'd0);
      check_output({tag, "_test_flag"}, 32'(test_flag), 32'd0);
      check_output({tag, "_x"}, 32'(x_input), 32'd0);
      check_output({tag, "_y"}, 32'(y_input), 32'd0);
      check_output({tag, "_busy"}, 32'(busy), 32'd0);
      check_output({tag, "_done"}, 32'(done), 32'd0);
      check_output({tag, "_epoch"}, 32'(epoch_count), 32'd0);
      check_output({tag, "_correct"}, 32'(correct_count), 32'd0);
      check_output({tag, "_pass"}, 32'(pass), 32'd0);
      check_output({tag, "_perr"}, 32'(protocol_err), 32'd0);
   endtask

   // One complete run; pred/expc hold the 2-bit codes for samples 0..3 (sample 0 in bits 1:0).
   task automatic apply_stimulus(input string name, input logic [7:0] pred, input logic [7:0] expc,
                                 input bit poke_start);
      int         good;
      bit         bad;
      logic [1:0] p, e;
      good = 0;
      bad  = 0;
      $display("[TB] run %s", name);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check_output({name, "_t0_busy"}, 32'(busy), 32'd0);
      tick(1);
      check_output({name, "_t1_busy"}, 32'(busy), 32'd1);
      check_output({name, "_t1_nn_reset"}, 32'(nn_reset), 32'd1);
      check_output({name, "_t1_reset_value"}, 32'(nn_reset_value), 32'd1);
      check_output({name, "_t1_test_flag"}, 32'(test_flag), 32'd0);
      check_output({name, "_t1_done"}, 32'(done), 32'd0);
      check_output({name, "_t1_epoch"}, 32'(epoch_count), 32'd0);
      check_output({name, "_t1_correct"}, 32'(correct_count), 32'd0);
      check_output({name, "_t1_perr"}, 32'(protocol_err), 32'd0);
      tick(1);
      check_output({name, "_t2_nn_reset"}, 32'(nn_reset), 32'd1);
      tick(1);
      check_output({name, "_t3_nn_reset"}, 32'(nn_reset), 32'd0);
      check_output({name, "_t3_reset_value"}, 32'(nn_reset_value), 32'd0);
      for (int s = 0; s < 4 * EPOCHS; s++) begin
         for (int c = 0; c < 8; c++) begin
            if (c == 0 || c == 7) begin
               check_output({name, "_train_x"}, 32'(x_input), 32'(s[1]));
               check_output({name, "_train_y"}, 32'(y_input), 32'(s[0]));
               check_output({name, "_train_test_flag"}, 32'(test_flag), 32'd0);
               check_output({name, "_train_busy"}, 32'(busy), 32'd1);
               check_output({name, "_train_epoch"}, 32'(epoch_count), 32'(s / 4));
            end
            if (poke_start && s == 2 && c == 3) start = 1'b1;
            if (poke_start && s == 2 && c == 4) start = 1'b0;
            tick(1);
         end
      end
      for (int i = 0; i < 4; i++) begin
         p = pred[2*i +: 2];
         e = expc[2*i +: 2];
         predicted = p;
         expected  = e;
         check_output({name, "_test_flag"}, 32'(test_flag), 32'd1);
         check_output({name, "_test_x"}, 32'(x_input), 32'(i[1]));
         check_output({name, "_test_y"}, 32'(y_input), 32'(i[0]));
         check_output({name, "_test_epoch"}, 32'(epoch_count), 32'(EPOCHS));
         tick(1);
         check_output({name, "_test_x_held"}, 32'(x_input), 32'(i[1]));
         check_output({name, "_test_done_low"}, 32'(done), 32'd0);
         tick(1);
         if (p == 2'b00 || e == 2'b00) bad = 1'b1;
         else if (p == e) good++;
         check_output({name, "_test_correct"}, 32'(correct_count), 32'(good));
         check_output({name, "_test_perr"}, 32'(protocol_err), 32'(bad));
      end
      check_output({name, "_done"}, 32'(done), 32'd1);
      check_output({name, "_done_busy"}, 32'(busy), 32'd0);
      check_output({name, "_done_test_flag"}, 32'(test_flag), 32'd0);
      check_output({name, "_done_x"}, 32'(x_input), 32'd0);
      check_output({name, "_done_y"}, 32'(y_input), 32'd0);
      check_output({name, "_done_pass"}, 32'(pass), 32'(good == 4));
      check_output({name, "_done_epoch"}, 32'(epoch_count), 32'(EPOCHS));
      tick(3);
      check_output({name, "_done_hold"}, 32'(done), 32'd1);
      check_output({name, "_done_hold_correct"}, 32'(correct_count), 32'(good));
      check_output({name, "_done_hold_perr"}, 32'(protocol_err), 32'(bad));
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      predicted = 2'b10;
      expected  = 2'b10;
      #2;
      check_all_zero("in_reset");
      tick(2);
      reset_n = 1'b1;
      tick(20);
      check_all_zero("idle_20");

      apply_stimulus("full", 8'b10_10_10_10, 8'b10_10_10_10, 1'b1);
      apply_stimulus("score", 8'b01_10_01_01, 8'b01_10_10_01, 1'b0);
      apply_stimulus("invalid", 8'b01_00_10_01, 8'b01_10_10_01, 1'b0);
      apply_stimulus("restart", 8'b01_10_10_01, 8'b01_10_10_01, 1'b0);

      // Partial run interrupted in epoch 1, sample 2, cycle 5.
      $display("[TB] run async_reset");
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(56);
      check_output("pre_reset_busy", 32'(busy), 32'd1);
      check_output("pre_reset_epoch", 32'(epoch_count), 32'd1);
      check_output("pre_reset_x", 32'(x_input), 32'd1);
      check_output("pre_reset_y", 32'(y_input), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      tick(2);
      reset_n = 1'b1;
      tick(2);
      check_all_zero("after_release");

      apply_stimulus("after_reset", 8'b01_10_10_01, 8'b01_10_10_01, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
